// File: rtl/silife_max7219_rx_if.sv
// silife_max7219_rx_if
//   Serial link and row read-back bundle for the MAX7219 receive model.
//   master : transmitter/observer side (drives CS/SCK/MOSI and the row select)
//   slave  : the receiver (samples the serial pins, returns row/intensity/pulses)
//   i_cs, i_sck, i_mosi : LOAD/CS (active low), serial clock, serial data MSB first
//   i_row_select        : row to read, row r = device r/8, digit r%8
//   o_row, o_intensity  : displayed pattern and intensity for the selected row
//   o_latch, o_frame_err: one-cycle pulses for a committed / discarded frame
interface silife_max7219_rx_if #(
    parameter int ROW_BITS = 5
);
    logic                i_cs;
    logic                i_sck;
    logic                i_mosi;
    logic [ROW_BITS-1:0] i_row_select;
    logic [7:0]          o_row;
    logic [3:0]          o_intensity;
    logic                o_latch;
    logic                o_frame_err;

    modport master (
        output i_cs, i_sck, i_mosi, i_row_select,
        input  o_row, o_intensity, o_latch, o_frame_err
    );

    modport slave (
        input  i_cs, i_sck, i_mosi, i_row_select,
        output o_row, o_intensity, o_latch, o_frame_err
    );
endinterface

// File: rtl/silife_max7219_rx.sv
// silife_max7219_rx
//   Receive-side model of a chain of CHAIN MAX7219 LED drivers. Decodes the
//   CS/SCK/MOSI stream into 16-bit words, one per device, and keeps each
//   device's digit and configuration registers. A row read port returns the
//   pattern a given display row would show.
//   clk   : system clock, the only clock
//   reset : synchronous, active-high reset
//   bus   : silife_max7219_rx_if slave modport (serial pins, row port, pulses)
module silife_max7219_rx #(
    parameter int CHAIN    = 4,
    parameter int ROW_BITS = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    silife_max7219_rx_if.slave     bus
);
    localparam int FRAME_BITS = 16 * CHAIN;
    localparam int CNT_W      = $clog2(FRAME_BITS + 2);
    localparam int DEV_W      = ROW_BITS - 3;

    // Synchronisers and edge history
    logic cs_ff1, cs_s, cs_d;
    logic sck_ff1, sck_s, sck_d;
    logic mosi_ff1, mosi_s;

    logic sck_rise, cs_rise, cs_fall;

    logic [FRAME_BITS-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt;

    // Per-device register file
    logic [7:0]            digit [CHAIN][8];
    logic [CHAIN-1:0][7:0] decode;
    logic [3:0]            intensity [CHAIN];
    logic [2:0]            scan_limit [CHAIN];
    logic [CHAIN-1:0]      shutdown_n;
    logic [CHAIN-1:0]      test;

    // The decode-mode register is kept for completeness but never shown.
    logic unused_decode;
    assign unused_decode = ^decode;

    assign sck_rise = sck_s && !sck_d;
    assign cs_rise  = cs_s && !cs_d;
    assign cs_fall  = !cs_s && cs_d;

    // Idle values on reset: CS high, SCK and MOSI low, so no spurious edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_ff1   <= 1'b1;
            cs_s     <= 1'b1;
            cs_d     <= 1'b1;
            sck_ff1  <= 1'b0;
            sck_s    <= 1'b0;
            sck_d    <= 1'b0;
            mosi_ff1 <= 1'b0;
            mosi_s   <= 1'b0;
        end else begin
            cs_ff1   <= bus.i_cs;
            cs_s     <= cs_ff1;
            cs_d     <= cs_s;
            sck_ff1  <= bus.i_sck;
            sck_s    <= sck_ff1;
            sck_d    <= sck_s;
            mosi_ff1 <= bus.i_mosi;
            mosi_s   <= mosi_ff1;
        end
    end

    // Shift register and bit counter. A CS rise judges the frame on the
    // count as it stands; a coincident SCK rise is ignored because cs_s=1.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            if (sck_rise && !cs_s) begin
                shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi_s};
            end
            if (cs_rise || cs_fall) begin
                bit_cnt <= '0;
            end else if (sck_rise && !cs_s && bit_cnt != CNT_W'(FRAME_BITS + 1)) begin
                // Saturating one past a full frame guarantees an over-long frame is discarded.
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // Commit: device d owns word d; the first word sent ends up in the top slice.
    // NOTE: the digit array is reset like any other register here because its
    // reset value is architecturally visible on o_row; a RAM-style array that
    // is always written before being read would not need it.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.o_latch     <= 1'b0;
            bus.o_frame_err <= 1'b0;
            decode          <= '0;
            shutdown_n      <= '0;
            test            <= '0;
            for (int d = 0; d < CHAIN; d++) begin
                intensity[d]  <= 4'h0;
                scan_limit[d] <= 3'd0;
                for (int k = 0; k < 8; k++) begin
                    digit[d][k] <= 8'h00;
                end
            end
        end else begin
            bus.o_latch     <= 1'b0;
            bus.o_frame_err <= 1'b0;
            if (cs_rise) begin
                if (bit_cnt == CNT_W'(FRAME_BITS)) begin
                    bus.o_latch <= 1'b1;
                    for (int d = 0; d < CHAIN; d++) begin
                        case (shift_reg[16*d+8 +: 4])
                            4'h9:    decode[d]     <= shift_reg[16*d +: 8];
                            4'hA:    intensity[d]  <= shift_reg[16*d +: 4];
                            4'hB:    scan_limit[d] <= shift_reg[16*d +: 3];
                            4'hC:    shutdown_n[d] <= shift_reg[16*d];
                            4'hF:    test[d]       <= shift_reg[16*d];
                            default: ;
                        endcase
                        for (int k = 0; k < 8; k++) begin
                            if (shift_reg[16*d+8 +: 4] == 4'(k + 1)) begin
                                digit[d][k] <= shift_reg[16*d +: 8];
                            end
                        end
                    end
                end else begin
                    bus.o_frame_err <= 1'b1;
                end
            end
        end
    end

    // Row read port: test overrides shutdown, which overrides the scan limit.
    logic [DEV_W-1:0] dev;
    logic [2:0]       k_sel;
    assign dev   = bus.i_row_select[ROW_BITS-1:3];
    assign k_sel = bus.i_row_select[2:0];

    // NOTE: every output of this combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        bus.o_row       = 8'h00;
        bus.o_intensity = 4'h0;
        if (int'(dev) < CHAIN) begin
            bus.o_intensity = intensity[dev];
            if (test[dev]) begin
                bus.o_row = 8'hFF;
            end else if (!shutdown_n[dev]) begin
                bus.o_row = 8'h00;
            end else if (k_sel > scan_limit[dev]) begin
                bus.o_row = 8'h00;
            end else begin
                bus.o_row = digit[dev][k_sel];
            end
        end
    end
endmodule

// File: tb/tb_silife_max7219_rx.sv
// tb_silife_max7219_rx
//   Directed bench for silife_max7219_rx (CHAIN=4). Bit-bangs frames on the
//   serial pins, counts o_latch/o_frame_err pulses after each CS rise and
//   sweeps the row read port against hand-computed grid contents.
module tb_silife_max7219_rx;
    localparam int CHAIN    = 4;
    localparam int ROW_BITS = 5;
    localparam int NROWS    = 8 * CHAIN;
    localparam int HALF     = 4;   // clk cycles per SCK phase

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    silife_max7219_rx_if #(.ROW_BITS(ROW_BITS)) bus ();

    silife_max7219_rx #(.CHAIN(CHAIN), .ROW_BITS(ROW_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends nbits MSB-first from data[63] downward (zeros beyond 64 bits),
    // raises CS and counts the pulses that follow.
    task automatic send_frame(input logic [63:0] data, input int nbits,
                              output int n_latch, output int n_err, output int n_both);
        n_latch = 0;
        n_err   = 0;
        n_both  = 0;
        bus.i_cs = 1'b0;
        wait_cycles(HALF);
        for (int i = 0; i < nbits; i++) begin
            bus.i_mosi = (i < 64) ? data[63-i] : 1'b0;
            bus.i_sck  = 1'b0;
            wait_cycles(HALF);
            bus.i_sck  = 1'b1;
            wait_cycles(HALF);
        end
        bus.i_sck = 1'b0;
        wait_cycles(HALF);
        bus.i_cs = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.o_latch)     n_latch++;
            if (bus.o_frame_err) n_err++;
            if (bus.o_latch && bus.o_frame_err) n_both++;
        end
    endtask

    task automatic frame_ok(input string tag, input logic [63:0] data);
        int nl, ne, nb;
        send_frame(data, 64, nl, ne, nb);
        check({tag, "_latch"}, nl, 1);
        check({tag, "_err"}, ne, 0);
    endtask

    task automatic frame_bad(input string tag, input logic [63:0] data, input int nbits);
        int nl, ne, nb;
        send_frame(data, nbits, nl, ne, nb);
        check({tag, "_latch"}, nl, 0);
        check({tag, "_err"}, ne, 1);
        check({tag, "_both"}, nb, 0);
    endtask

    task automatic check_row(input int r, input logic [7:0] exp_row);
        bus.i_row_select = ROW_BITS'(r);
        #1;
        check($sformatf("row%0d", r), bus.o_row, exp_row);
    endtask

    task automatic check_int(input int r, input logic [3:0] exp_int);
        bus.i_row_select = ROW_BITS'(r);
        #1;
        check($sformatf("int_row%0d", r), bus.o_intensity, exp_int);
    endtask

    initial begin
        int nl, ne, nb;

        bus.i_cs         = 1'b1;
        bus.i_sck        = 1'b0;
        bus.i_mosi       = 1'b0;
        bus.i_row_select = '0;
        reset            = 1'b1;
        wait_cycles(5);
        reset = 1'b0;
        wait_cycles(5);

        // Reset state
        for (int r = 0; r < NROWS; r++) begin
            check_row(r, 8'h00);
            check_int(r, 4'h0);
            check("rst_latch", bus.o_latch, 1'b0);
            check("rst_err", bus.o_frame_err, 1'b0);
        end

        // Enable, full scan, digit 2 of device 0 = 0x81
        frame_ok("en",   {4{16'h0C01}});
        frame_ok("scan", {4{16'h0B07}});
        frame_ok("dig2", {16'h0000, 16'h0000, 16'h0000, 16'h0381});
        for (int r = 0; r < NROWS; r++) begin
            check_row(r, (r == 2) ? 8'h81 : 8'h00);
        end

        // Chain ordering: first word sent lands on the far device
        frame_ok("chain", {16'h0155, 16'h01AA, 16'h010F, 16'h01F0});
        check_row(24, 8'h55);
        check_row(16, 8'hAA);
        check_row(8,  8'h0F);
        check_row(0,  8'hF0);
        check_row(2,  8'h81);

        // Scan limit
        frame_ok("lim2", {4{16'h0B02}});
        frame_ok("dig4", {4{16'h053C}});
        check_row(4,  8'h00);
        check_row(2,  8'h81);
        check_row(12, 8'h00);
        frame_ok("lim7", {4{16'h0B07}});
        check_row(4,  8'h3C);
        check_row(12, 8'h3C);
        check_row(28, 8'h3C);

        // Display test overrides everything
        frame_ok("test1", {4{16'h0F01}});
        for (int r = 0; r < NROWS; r++) begin
            check_row(r, 8'hFF);
        end
        frame_ok("test0", {4{16'h0F00}});
        check_row(4, 8'h3C);
        check_row(5, 8'h00);

        // Bad frames leave registers untouched
        frame_bad("short63", {4{16'h0F01}}, 63);
        check_row(4, 8'h3C);
        check_row(7, 8'h00);
        frame_bad("long65", {4{16'h0F01}}, 65);
        check_row(4, 8'h3C);
        check_row(7, 8'h00);
        frame_ok("after_bad", {4{16'h0601}});
        check_row(5,  8'h01);
        check_row(29, 8'h01);
        check_row(4,  8'h3C);

        // Intensity on device 1 only
        frame_ok("inten", {16'h0000, 16'h0000, 16'h0A09, 16'h0000});
        for (int r = 0; r < NROWS; r++) begin
            check_int(r, (r >= 8 && r < 16) ? 4'h9 : 4'h0);
        end

        // Reset in the middle of a frame, then CS rise with no new CS fall
        bus.i_cs = 1'b0;
        wait_cycles(HALF);
        for (int i = 0; i < 20; i++) begin
            bus.i_mosi = i[0];
            bus.i_sck  = 1'b0;
            wait_cycles(HALF);
            bus.i_sck  = 1'b1;
            wait_cycles(HALF);
        end
        bus.i_sck = 1'b0;
        wait_cycles(HALF);
        reset = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(HALF);
        nl = 0;
        ne = 0;
        bus.i_cs = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.o_latch)     nl++;
            if (bus.o_frame_err) ne++;
        end
        check("midrst_err", ne, 1);
        check("midrst_latch", nl, 0);
        for (int r = 0; r < NROWS; r++) begin
            check_row(r, 8'h00);
            check_int(r, 4'h0);
        end

        // Registers really went back to defaults: re-enable without rewriting digits
        frame_ok("reen", {4{16'h0C01}});
        check_row(0, 8'h00);
        check_row(2, 8'h00);
        check_row(1, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/silife_max7219_rx.md
# silife_max7219_rx

SPI receive-side model of a daisy chain of MAX7219 LED drivers. It takes the CS/SCK/MOSI stream produced by the MAX7219 transmitter, decodes the 16-bit command words, and keeps per-device digit and configuration registers. A row read port returns the 8-bit pattern each displayed row would show, so the display path can be checked cycle-accurately against the 8x32 grid contents, or mirrored on-chip.

## Interface

Parameters:
- CHAIN, default 4: number of cascaded devices; each device holds 8 rows.
- ROW_BITS, default 5: width of the row select, equal to clog2(8*CHAIN).

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- i_cs  input  1  LOAD/CS from the transmitter. Active low; a rising edge latches the frame.
- i_sck  input  1  serial clock; data is sampled on its rising edge.
- i_mosi  input  1  serial data, MSB first.
- i_row_select  input  ROW_BITS  row to read; row r maps to device r/8, digit r%8.
- o_row  output  8  displayed pattern of the selected row (combinational from registers).
- o_intensity  output  4  intensity register of the device that owns the selected row.
- o_latch  output  1  one-cycle pulse after a valid frame has been committed.
- o_frame_err  output  1  one-cycle pulse when a frame is discarded.

## Operation

Input synchronisation and edge detection:
- i_cs, i_sck and i_mosi each pass through a 2-FF synchroniser, giving cs_s, sck_s and mosi_s.
- A SCK rise is sck_s=1 while the previous sck_s=0.
- A CS rise and a CS fall are detected the same way on cs_s.

Shifting:
- On a SCK rise with cs_s=0, shift_reg (16*CHAIN bits) shifts left with mosi_s entering at the LSB.
- On the same event, bit_cnt increments, saturating at 16*CHAIN+1.
- A SCK rise with cs_s=1 is ignored.

CS fall:
- bit_cnt is cleared to 0.
- shift_reg is not cleared.

CS rise:
- If bit_cnt == 16*CHAIN, the frame is committed.
- Otherwise the frame is discarded and o_frame_err pulses.
- After either outcome, bit_cnt returns to 0.

Commit rules:
- Device d takes word shift_reg[16*d +: 16]. Device 0 is the one nearest the transmitter and receives the last word sent; the first word sent lands on device CHAIN-1.
- Bits 15:12 of each word are ignored; address = bits 11:8, data = bits 7:0.
- Address 0x0 is a no-op.
- Addresses 0x1–0x8 write digit[addr-1].
- Address 0x9 writes decode (8 bits; stored only and does not affect o_row).
- Address 0xA writes intensity = data[3:0].
- Address 0xB writes scan_limit = data[2:0].
- Address 0xC writes shutdown_n = data[0].
- Address 0xF writes test = data[0].
- Addresses 0xD and 0xE are ignored.
- All CHAIN devices update in the same cycle.

Row output, for the selected device and digit k, in priority order:
1. test=1: o_row = 0xFF.
2. shutdown_n=0: o_row = 0x00.
3. k > scan_limit: o_row = 0x00.
4. Otherwise: o_row = digit[k].

Reset values:
- All digits 0x00; decode 0x00; intensity 0x0; scan_limit 0; shutdown_n 0; test 0.
- shift_reg 0; bit_cnt 0.
- Synchroniser and edge-history flops take their idle values: cs=1, sck=0, mosi=0.
- Outputs: o_row 0x00, o_intensity 0x0, o_latch 0, o_frame_err 0.

## Timing

- A SCK pin rise is shifted 3 clk cycles later: 2 synchroniser stages plus the edge register.
- A CS pin rise produces register update and the o_latch (or o_frame_err) pulse 3 cycles later; the registers are visible on o_row in that same cycle.
- SCK high and low phases must each last at least 3 clk cycles. CS must stay high at least 3 cycles between frames. Faster input is outside the spec.
- If a SCK rise and a CS rise are detected in the same cycle, cs_s is already 1, so the bit is not shifted and the frame is judged on the current bit_cnt.
- Reset asserted mid-frame clears all state. A CS rise arriving later with no CS fall after reset sees bit_cnt=0 and produces o_frame_err.
- Extra SCK edges beyond 16*CHAIN saturate the counter and guarantee a discard; the registers are untouched.
- o_latch and o_frame_err are never asserted in the same cycle.

## Test plan

- Reset check: apply reset, then sweep i_row_select 0..31 -> every o_row = 0x00, o_intensity = 0, no pulses.
- Enable and write a row:
  - Send frame 4×0x0C01, then frame 4×0x0B07, then a frame whose last word is 0x0381 and whose other words are 0x0000.
  - Expect exactly one o_latch per frame.
  - Row 2 reads 0x81; rows 0,1 and 3..31 read 0x00.
- Chain ordering: send frame 0x0155, 0x01AA, 0x010F, 0x01F0 after enabling all devices -> rows 24, 16, 8, 0 read 0x55, 0xAA, 0x0F, 0xF0 respectively.
- Scan limit and test:
  - Set scan_limit 0x0B02 on all devices and write digit 4 = 0x3C -> row 4 reads 0x00.
  - Then 0x0B07 on all -> row 4 reads 0x3C.
  - Then 0x0F01 on all -> every row reads 0xFF.
- Bad frames:
  - A 63-bit frame produces o_frame_err, no o_latch, and no register change.
  - A 65-bit frame behaves the same way.
  - A following correct 64-bit frame commits normally.
- Intensity and reset mid-frame:
  - Write 0x0A09 to device 1 only -> o_intensity = 9 for rows 8..15 and 0 elsewhere.
  - Assert reset after 20 bits of the next frame, then raise CS -> all registers at reset values, and o_frame_err pulses once.
